// File: rtl/fft_pkg.sv
// Shared constants, payload type and helpers for the 16-point R2SDF FFT datapath.
//   WIDTH     bits per real/imaginary component
//   LOG2N     log2 of frame length, N samples per frame
//   sample_t  packed {re, im} payload stored in the reorder RAM
//   BANK_*    ping-pong bank state encoding
//   bitrev()  reverses the LOG2N low bits of a sample index
package fft_pkg;

  localparam int unsigned WIDTH     = 35;
  localparam int unsigned LOG2N     = 4;
  localparam int unsigned N         = 2 ** LOG2N;
  localparam int unsigned ADDR_W    = LOG2N + 1;  // bank bit + sample index
  localparam int unsigned BANK_ST_W = 2;

  localparam logic [BANK_ST_W-1:0] BANK_EMPTY    = 2'd0;
  localparam logic [BANK_ST_W-1:0] BANK_FILLING  = 2'd1;
  localparam logic [BANK_ST_W-1:0] BANK_FULL     = 2'd2;
  localparam logic [BANK_ST_W-1:0] BANK_DRAINING = 2'd3;

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } sample_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LOG2N); i++) begin
      r[i] = a[int'(LOG2N) - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Two-bank sample store for the FFT output reorder stage.
//   i_clk      write clock
//   i_we       write enable
//   i_waddr    {bank, index} write address
//   i_wdata    sample to store
//   i_raddr    {bank, index} read address
//   o_rdata_c  combinational read data
module fft_reorder_ram
  import fft_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  sample_t           i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output sample_t           o_rdata_c
);

  sample_t r_mem [2*N];

  // Synchronous write; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Output reorder stage of the 16-point R2SDF FFT: accepts bit-reversed frames and
// re-emits them in natural bin order through a ping-pong pair of banks.
//   iClk, iRst_n          clock, async active-low reset
//   iEn, iSof             input valid, first sample of frame (resync aid)
//   iData_Re, iData_Im    input sample, bit-reversed order
//   oValid, oSof          output valid, bin 0 marker
//   oData_Re, oData_Im    output sample, natural order, held when oValid=0
//   oFrameErr             one-cycle pulse when a partial input frame is dropped
module fft_bitrev_reorder
  import fft_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEn,
  input  logic             iSof,
  input  logic [WIDTH-1:0] iData_Re,
  input  logic [WIDTH-1:0] iData_Im,
  output logic             oValid,
  output logic             oSof,
  output logic [WIDTH-1:0] oData_Re,
  output logic [WIDTH-1:0] oData_Im,
  output logic             oFrameErr
);

  localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

  logic                             r_wr_bank;
  logic [LOG2N-1:0]                 r_wr_cnt;
  logic                             r_rd_bank;
  logic [LOG2N-1:0]                 r_rd_cnt;
  logic                             r_rd_active;
  logic [1:0][BANK_ST_W-1:0]        r_bank_st;

  logic                             w_wr_bank_nxt;
  logic [LOG2N-1:0]                 w_wr_cnt_nxt;
  logic                             w_rd_bank_nxt;
  logic [LOG2N-1:0]                 w_rd_cnt_nxt;
  logic                             w_rd_active_nxt;
  logic [1:0][BANK_ST_W-1:0]        w_bank_st_nxt;
  logic [LOG2N-1:0]                 w_wr_cnt_eff;
  logic                             w_frame_err;
  logic                             w_rd_en;
  logic                             w_rd_sof;
  logic [ADDR_W-1:0]                w_waddr;
  logic [ADDR_W-1:0]                w_raddr;
  sample_t                          w_wdata;
  sample_t                          w_rdata;

  // A resync iSof restarts the current bank at index 0.
  assign w_wr_cnt_eff = iSof ? '0 : r_wr_cnt;
  assign w_waddr      = {r_wr_bank, bitrev(w_wr_cnt_eff)};
  assign w_raddr      = {r_rd_bank, r_rd_cnt};
  assign w_wdata      = '{re: iData_Re, im: iData_Im};

  fft_reorder_ram u_ram (
    .i_clk     (iClk),
    .i_we      (iEn),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr   (w_raddr),
    .o_rdata_c (w_rdata)
  );

  // Next-state logic for write counter, read counter and both bank FSMs.
  always_comb begin
    w_wr_bank_nxt   = r_wr_bank;
    w_wr_cnt_nxt    = r_wr_cnt;
    w_rd_bank_nxt   = r_rd_bank;
    w_rd_cnt_nxt    = r_rd_cnt;
    w_rd_active_nxt = r_rd_active;
    w_bank_st_nxt   = r_bank_st;
    w_frame_err     = 1'b0;
    w_rd_en         = 1'b0;

    if (iEn) begin
      w_frame_err = iSof && (r_wr_cnt != '0);
      if (w_wr_cnt_eff == CNT_LAST) begin
        w_bank_st_nxt[r_wr_bank] = BANK_FULL;
        w_wr_bank_nxt            = ~r_wr_bank;
        w_wr_cnt_nxt             = '0;
      end else begin
        w_bank_st_nxt[r_wr_bank] = BANK_FILLING;
        w_wr_cnt_nxt             = w_wr_cnt_eff + CNT_ONE;
      end
    end

    // Bin 0 is read in the same cycle the bank is seen FULL, so output trails the
    // last write by exactly one edge and back-to-back frames drain without a gap.
    if (r_rd_active) begin
      w_rd_en = 1'b1;
      if (r_rd_cnt == CNT_LAST) begin
        w_bank_st_nxt[r_rd_bank] = BANK_EMPTY;
        w_rd_active_nxt          = 1'b0;
        w_rd_bank_nxt            = ~r_rd_bank;
        w_rd_cnt_nxt             = '0;
      end else begin
        w_rd_cnt_nxt = r_rd_cnt + CNT_ONE;
      end
    end else if (r_bank_st[r_rd_bank] == BANK_FULL) begin
      w_rd_en                  = 1'b1;
      w_bank_st_nxt[r_rd_bank] = BANK_DRAINING;
      w_rd_active_nxt          = 1'b1;
      w_rd_cnt_nxt             = CNT_ONE;
    end
  end

  assign w_rd_sof = w_rd_en && (r_rd_cnt == '0);

  // Control state registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_rd_active <= 1'b0;
      r_bank_st   <= {2{BANK_EMPTY}};
    end else begin
      if (iEn) begin
        assert (r_bank_st[r_wr_bank] != BANK_FULL &&
                r_bank_st[r_wr_bank] != BANK_DRAINING);
      end
      r_wr_bank   <= w_wr_bank_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_rd_active <= w_rd_active_nxt;
      r_bank_st   <= w_bank_st_nxt;
    end
  end

  // Output registers; data holds its last value while idle.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oValid    <= 1'b0;
      oSof      <= 1'b0;
      oData_Re  <= '0;
      oData_Im  <= '0;
      oFrameErr <= 1'b0;
    end else begin
      oValid    <= w_rd_en;
      oSof      <= w_rd_sof;
      oFrameErr <= w_frame_err;
      if (w_rd_en) begin
        oData_Re <= w_rdata.re;
        oData_Im <= w_rdata.im;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;
  import fft_pkg::*;

  localparam int unsigned W = WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         sof = 1'b0;
  logic [W-1:0] d_re = '0;
  logic [W-1:0] d_im = '0;
  logic         o_valid, o_sof, o_err;
  logic [W-1:0] o_re, o_im;

  fft_bitrev_reorder dut (
    .iClk      (clk),
    .iRst_n    (rst_n),
    .iEn       (en),
    .iSof      (sof),
    .iData_Re  (d_re),
    .iData_Im  (d_im),
    .oValid    (o_valid),
    .oSof      (o_sof),
    .oData_Re  (o_re),
    .oData_Im  (o_im),
    .oFrameErr (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         sof;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           err_q[$];
  logic [W-1:0] buf_re[$];
  logic [W-1:0] buf_im[$];
  logic [W-1:0] obs_log[$];
  logic [W-1:0] last_re = '0;
  logic [W-1:0] last_im = '0;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  function automatic int ref_bitrev(input int x);
    int r = 0;
    for (int b = 0; b < int'(LOG2N); b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom()});
  endfunction

  // Frame-level model: collect a frame, then schedule its bins in natural order.
  task automatic model_write(input logic [W-1:0] re, input logic [W-1:0] im,
                             input logic s, input int e_idx);
    exp_t e;
    if (s && buf_re.size() != 0) begin
      buf_re.delete();
      buf_im.delete();
      err_q.push_back(e_idx);
    end
    buf_re.push_back(re);
    buf_im.push_back(im);
    if (buf_re.size() == int'(N)) begin
      for (int j = 0; j < int'(N); j++) begin
        e.re  = buf_re[ref_bitrev(j)];
        e.im  = buf_im[ref_bitrev(j)];
        e.sof = (j == 0);
        e.cyc = e_idx + 1 + j;
        exp_q.push_back(e);
      end
      buf_re.delete();
      buf_im.delete();
    end
  endtask

  task automatic check_cycle();
    logic exp_v, exp_err;
    exp_t e;
    exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    chk("valid", 70'(o_valid), 70'(exp_v));
    if (exp_v) begin
      e = exp_q.pop_front();
      chk("data_re", 70'(o_re), 70'(e.re));
      chk("data_im", 70'(o_im), 70'(e.im));
      chk("sof", 70'(o_sof), 70'(e.sof));
      obs_log.push_back(o_re);
      last_re = e.re;
      last_im = e.im;
    end else begin
      chk("sof_idle", 70'(o_sof), 70'(0));
      chk("hold_re", 70'(o_re), 70'(last_re));
      chk("hold_im", 70'(o_im), 70'(last_im));
    end
    exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
    if (exp_err) void'(err_q.pop_front());
    chk("frame_err", 70'(o_err), 70'(exp_err));
  endtask

  task automatic tick(input logic t_en, input logic t_sof,
                      input logic [W-1:0] t_re, input logic [W-1:0] t_im);
    en   = t_en;
    sof  = t_sof;
    d_re = t_re;
    d_im = t_im;
    if (t_en && rst_n) model_write(t_re, t_im, t_sof, cyc + 1);
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, rnd(), rnd());
  endtask

  task automatic reset_model();
    exp_q.delete();
    err_q.delete();
    buf_re.delete();
    buf_im.delete();
    last_re = '0;
    last_im = '0;
  endtask

  int           t1_order[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  logic [W-1:0] ext_re = 35'h4_0000_0000;
  logic [W-1:0] ext_im = 35'h3_FFFF_FFFF;

  initial begin
    int written;
    int guard;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 70'(o_valid), 70'(0));
    chk("rst_sof", 70'(o_sof), 70'(0));
    chk("rst_err", 70'(o_err), 70'(0));
    chk("rst_re", 70'(o_re), 70'(0));
    chk("rst_im", 70'(o_im), 70'(0));
    rst_n = 1'b1;
    idle(2);

    // Single frame, Re=i, Im=-i
    obs_log.delete();
    for (int i = 0; i < 16; i++) tick(1'b1, i == 0, W'(i), W'(-i));
    idle(18);
    chk("t1_count", 70'(obs_log.size()), 70'(16));
    for (int j = 0; j < 16 && j < obs_log.size(); j++)
      chk("t1_order", 70'(obs_log[j]), 70'(t1_order[j]));

    // Three back-to-back frames
    for (int i = 0; i < 48; i++) tick(1'b1, (i % 16) == 0, rnd(), rnd());
    idle(18);

    // Half-rate input, frame without iSof
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b0, rnd(), rnd());
      tick(1'b0, 1'b0, rnd(), rnd());
    end
    idle(18);

    // Resync at write count 5
    for (int i = 0; i < 5; i++) tick(1'b1, i == 0, rnd(), rnd());
    for (int i = 0; i < 16; i++) tick(1'b1, i == 0, rnd(), rnd());
    idle(18);

    // Reset while bin 7 is on the output
    for (int i = 0; i < 16; i++) tick(1'b1, i == 0, rnd(), rnd());
    idle(8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 70'(o_valid), 70'(0));
    chk("mid_rst_sof", 70'(o_sof), 70'(0));
    chk("mid_rst_re", 70'(o_re), 70'(0));
    chk("mid_rst_im", 70'(o_im), 70'(0));
    reset_model();
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, rnd(), rnd());
    idle(5);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, rnd(), rnd());
    idle(18);

    // Extreme values pass bit-exact
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) tick(1'b1, i == 0, ext_re, ext_im);
      else            tick(1'b1, 1'b0, ext_im, ext_re);
    end
    idle(18);

    // Random valid pattern with occasional resyncs
    written = 0;
    guard   = 0;
    while (written < 64 && guard < 2000) begin
      guard++;
      if ($urandom_range(0, 9) < 7) begin
        tick(1'b1, (written % 16 == 0) || ($urandom_range(0, 39) == 0), rnd(), rnd());
        written++;
      end else begin
        tick(1'b0, 1'b0, rnd(), rnd());
      end
    end
    idle(40);

    chk("drained", 70'(exp_q.size()), 70'(0));
    chk("err_drained", 70'(err_q.size()), 70'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
